// File: rtl/ram_write_queue.sv
// Purpose : multi-lane write staging queue feeding the XOR multi-port RAM write ports, oldest write on port 0.
// Latency : 1 cycle minimum from acceptance to wen/waddr/wdata; there is no same-cycle bypass.
// Backpres: in_ready is all-or-nothing per input group and comes from registered state only; the RAM side never stalls.
//
// Ports:
//   clk, resetn             clock, synchronous active-low reset
//   in_valid/addr/data      N_IN producer lanes (sparse allowed), accepted together when in_ready
//   in_ready                whole input group accepted this cycle
//   wen/waddr/wdata         N_WRITE RAM write ports, drained oldest-first on ascending port index
//   count, empty            registered occupancy and count == 0
module ram_write_queue #(
  parameter int WIDTH   = 32,
  parameter int DEPTH   = 32,
  parameter int N_IN    = 2,
  parameter int N_WRITE = 2,
  parameter int QDEPTH  = 8,
  localparam int ADDR_WIDTH = $clog2(DEPTH),
  localparam int CNT_W      = $clog2(QDEPTH + 1)
) (
  input  logic                                  clk,
  input  logic                                  resetn,
  input  logic [N_IN-1:0]                       in_valid,
  input  logic [N_IN-1:0][ADDR_WIDTH-1:0]       in_addr,
  input  logic [N_IN-1:0][WIDTH-1:0]            in_data,
  output logic                                  in_ready,
  output logic [N_WRITE-1:0]                    wen,
  output logic [N_WRITE-1:0][ADDR_WIDTH-1:0]    waddr,
  output logic [N_WRITE-1:0][WIDTH-1:0]         wdata,
  output logic [CNT_W-1:0]                      count,
  output logic                                  empty
);

  localparam int PTR_W = (QDEPTH > 1) ? $clog2(QDEPTH) : 1;

  typedef logic [PTR_W-1:0] ptr_t;
  typedef logic [CNT_W-1:0] cnt_t;

  typedef struct packed {
    logic [ADDR_WIDTH-1:0] addr;
    logic [WIDTH-1:0]      data;
  } entry_t;

  // Entry storage carries no reset: contents are meaningless until covered by head..tail.
  entry_t entries [QDEPTH];

  ptr_t head;
  ptr_t tail;
  cnt_t count_q;

  cnt_t deq;
  cnt_t enq;
  cnt_t free_slots;
  ptr_t slot_off [N_IN];

  // Drain amount and readiness. Slots vacated by this cycle's drain are counted as free,
  // so a full queue that is draining can still accept a group; the write lands at the edge,
  // after the combinational read of the same slot has already been presented.
  always_comb begin
    deq        = (count_q < cnt_t'(N_WRITE)) ? count_q : cnt_t'(N_WRITE);
    free_slots = cnt_t'(QDEPTH) - count_q + deq;
    in_ready   = (free_slots >= cnt_t'(N_IN));
  end

  // Lane compaction: each valid lane's slot offset is the number of valid lanes below it.
  always_comb begin
    enq = '0;
    for (int i = 0; i < N_IN; i++) begin
      slot_off[i] = ptr_t'(enq);
      if (in_valid[i]) begin
        enq = enq + cnt_t'(1);
      end
    end
  end

  // Drain ports: port k carries entry head+k, pointer wrap is implicit in the power-of-two width.
  always_comb begin
    wen   = '0;
    waddr = '0;
    wdata = '0;
    for (int k = 0; k < N_WRITE; k++) begin
      if (cnt_t'(k) < deq) begin
        wen[k]   = 1'b1;
        waddr[k] = entries[head + ptr_t'(k)].addr;
        wdata[k] = entries[head + ptr_t'(k)].data;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      head    <= '0;
      tail    <= '0;
      count_q <= '0;
    end else begin
      head <= head + ptr_t'(deq);
      if (in_ready) begin
        tail    <= tail + ptr_t'(enq);
        count_q <= count_q - deq + enq;
      end else begin
        count_q <= count_q - deq;
      end
    end
  end

  // Inputs presented during reset are dropped along with the queue contents.
  always_ff @(posedge clk) begin
    if (resetn && in_ready) begin
      for (int i = 0; i < N_IN; i++) begin
        if (in_valid[i]) begin
          entries[tail + slot_off[i]] <= '{addr: in_addr[i], data: in_data[i]};
        end
      end
    end
  end

  assign count = count_q;
  assign empty = (count_q == '0);

endmodule
